// File: rtl/fifo_flagged.sv
// rtl/fifo_flagged.sv - flagged synchronous FIFO with level and sticky error flags
//
// Purpose: buffers words between the transceiver datapath and its bus-side
// consumer. Storage is a register array. Reads are registered by default.
// Defining FIFO_FWFT_EN selects first-word-fall-through reads instead.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   write/data_in write request and write data
//   read          read request (pop acknowledge in FWFT mode)
//   data_out      read data
//   valid         data_out holds a newly read word (FWFT: head word present)
//   flush         synchronous clear of contents
//   clear_err     synchronous clear of overflow/underflow
//   level         number of stored words
//   full/empty    level at depth / at zero
//   almost_full   level >= AlmostFullLevel
//   almost_empty  level <= AlmostEmptyLevel
//   overflow      sticky, a write was rejected
//   underflow     sticky, a read was rejected
module fifo_flagged #(
  parameter int AddrWidth        = 3,
  parameter int DataWidth        = 8,
  parameter int AlmostFullLevel  = 6,
  parameter int AlmostEmptyLevel = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 write,
  input  logic [DataWidth-1:0] data_in,
  input  logic                 read,
  output logic [DataWidth-1:0] data_out,
  output logic                 valid,
  input  logic                 flush,
  input  logic                 clear_err,
  output logic [AddrWidth:0]   level,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int Depth = 2 ** AddrWidth;
  localparam logic [AddrWidth:0]   LevelFull = {1'b1, {AddrWidth{1'b0}}};
  localparam logic [AddrWidth:0]   LevelAf   = (AddrWidth + 1)'(AlmostFullLevel);
  localparam logic [AddrWidth:0]   LevelAe   = (AddrWidth + 1)'(AlmostEmptyLevel);
  localparam logic [AddrWidth:0]   LevelOne  = (AddrWidth + 1)'(1);
  localparam logic [AddrWidth-1:0] PtrOne    = AddrWidth'(1);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [DataWidth-1:0] mem_d [Depth];
  logic [AddrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [AddrWidth:0]   level_q, level_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;
  logic                 rd_acc, wr_acc, rd_rej, wr_rej;

  assign empty        = (level_q == '0);
  assign full         = (level_q == LevelFull);
  assign almost_full  = (level_q >= LevelAf);
  assign almost_empty = (level_q <= LevelAe);
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A full FIFO still takes a write when the head leaves in the same cycle.
  // Flush suppresses both accepting and flagging.
  assign rd_acc = read && !empty && !flush;
  assign wr_acc = write && (!full || rd_acc) && !flush;
  assign rd_rej = read && !flush && !rd_acc;
  assign wr_rej = write && !flush && !wr_acc;

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_acc) begin
      mem_d[wr_ptr_q] = data_in;
      wr_ptr_d        = wr_ptr_q + PtrOne;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end
    case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + LevelOne;
      2'b01:   level_d = level_q - LevelOne;
      default: level_d = level_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end

    // Setting wins over clearing in the same cycle.
    if (clear_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wr_rej) overflow_d = 1'b1;
    if (rd_rej) underflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is presented directly; read only advances the pointer.
  assign data_out = mem_q[rd_ptr_q];
  assign valid    = !empty;
`else
  logic [DataWidth-1:0] data_out_q, data_out_d;
  logic                 valid_q, valid_d;

  // mem_q still holds the old head when a full FIFO is read and written
  // together, so the outgoing word is never the one being overwritten.
  always_comb begin
    data_out_d = data_out_q;
    valid_d    = rd_acc;
    if (rd_acc) data_out_d = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
    end
  end

  assign data_out = data_out_q;
  assign valid    = valid_q;
`endif

endmodule

// File: tb/tb_fifo_flagged.sv
// tb/tb_fifo_flagged.sv - scoreboard testbench for fifo_flagged
module tb_fifo_flagged;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       write;
  logic [7:0] data_in;
  logic       read;
  logic [7:0] data_out;
  logic       valid;
  logic       flush;
  logic       clear_err;
  logic [3:0] level;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;

  fifo_flagged #(
    .AddrWidth(3), .DataWidth(8), .AlmostFullLevel(6), .AlmostEmptyLevel(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .write(write), .data_in(data_in), .read(read),
    .data_out(data_out), .valid(valid), .flush(flush), .clear_err(clear_err),
    .level(level), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int errors = 0;

  // Reference model: contents as a plain queue, errors as two bits.
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;
  logic [7:0] last_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every valid pulse must match the oldest outstanding read.
  always @(negedge clk) begin
    if (rst_n) begin
`ifndef FIFO_FWFT_EN
      if (valid) begin
        if (exp_q.size() == 0) begin
          tests++;
          errors++;
          $display("FAIL valid_spurious: got valid=1 data 0x%0h expected no pulse at %0t",
                   data_out, $time);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check("data_out", 32'(data_out), 32'(e));
          last_data = e;
        end
      end else begin
        check("data_hold", 32'(data_out), 32'(last_data));
      end
`endif
    end
  end

  task automatic check_state();
    int n;
    n = mq.size();
    check("level", 32'(level), n);
    check("empty", 32'(empty), 32'(n == 0));
    check("full", 32'(full), 32'(n == 8));
    check("almost_full", 32'(almost_full), 32'(n >= 6));
    check("almost_empty", 32'(almost_empty), 32'(n <= 1));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("underflow", 32'(underflow), 32'(m_unf));
`ifdef FIFO_FWFT_EN
    check("fwft_valid", 32'(valid), 32'(n != 0));
    if (n != 0) check("fwft_data", 32'(data_out), 32'(mq[0]));
`endif
  endtask

  // One clock of stimulus; the model applies the accept rules to its
  // pre-edge contents, then the registered state is compared after the edge.
  task automatic step(input logic w, input logic [7:0] d, input logic r,
                      input logic f, input logic c);
    logic ra, wa;
    @(negedge clk);
    #1;
    write = w; data_in = d; read = r; flush = f; clear_err = c;
    if (c) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (f) begin
      mq.delete();
    end else begin
      ra = r && (mq.size() > 0);
      wa = w && ((mq.size() < 8) || ra);
      if (ra) exp_q.push_back(mq.pop_front());
      if (wa) mq.push_back(d);
      if (w && !wa) m_ovf = 1'b1;
      if (r && !ra) m_unf = 1'b1;
    end
    @(posedge clk);
    #1;
    write = 1'b0; read = 1'b0; flush = 1'b0; clear_err = 1'b0;
    check_state();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    mq.delete();
    exp_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    last_data = 8'h00;
    #1;
    check_state();
    check("rst_valid", 32'(valid), 0);
`ifndef FIFO_FWFT_EN
    check("rst_data_out", 32'(data_out), 0);
`endif
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b1; write = 1'b0; data_in = 8'h00; read = 1'b0;
    flush = 1'b0; clear_err = 1'b0;
    #2;
    do_reset();

    // Basic three-word round trip.
    step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    idle(2);

    // Fill, overflow, drain, then a second fill to cross the pointer wrap.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) step(1'b1, 8'(i + 16 * k), 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    end

    // Simultaneous read and write at full.
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    idle(1);

    // Simultaneous read and write at empty, then clear the error.
    step(1'b1, 8'h5C, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    idle(1);

    // Flush at level 5 with a write pending, then a round trip.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
    step(1'b1, 8'h3D, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    idle(1);

    // Randomised traffic with an asynchronous reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      logic w, r, f, c;
      int bias;
      bias = (i / 300) % 3;
      w = ($urandom_range(0, 9) < (bias == 0 ? 7 : (bias == 1 ? 3 : 5)));
      r = ($urandom_range(0, 9) < (bias == 0 ? 3 : (bias == 1 ? 7 : 5)));
      f = ($urandom_range(0, 99) < 2);
      c = ($urandom_range(0, 99) < 5);
      if (i == 1500) do_reset();
      step(w, 8'($urandom), r, f, c);
    end
    idle(2);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
